// File: rtl/imem_resp.sv
// ---------------------------------------------------------------------------
// imem_resp
// Instruction memory with a load phase and a run phase.
//
// The block powers up in LOAD. In LOAD it accepts program words and keeps
// its response outputs quiet. A load_done pulse moves it to RUN. In RUN the
// memory is read-only, and the block answers one fetch address every cycle
// with a latency of one cycle.
//
// Parameters
//   N      instruction address width in bits
//   DEPTH  number of 32-bit words stored (power of two, 2..1024)
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   imem_addr_F  byte address from the fetch stage, sampled every RUN cycle
//   load_en      program-load write strobe (LOAD only)
//   load_addr    word index for the program-load write
//   load_data    instruction word for the program-load write
//   load_done    one-cycle pulse that ends program load
//   instr_F      served word, NOP on a fault, zero otherwise
//   instr_valid  instr_F holds a served word
//   fault        last sampled address was misaligned or out of range
//   fetch_count  saturating count of good responses
// ---------------------------------------------------------------------------
module imem_resp #(
   parameter int N     = 64,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N-1:0]             imem_addr_F,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   input  logic                     load_done,
   output logic [31:0]              instr_F,
   output logic                     instr_valid,
   output logic                     fault,
   output logic [31:0]              fetch_count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [31:0] NOP     = 32'hD503201F;
   localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_reg;
   state_t        state_next;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   rd_data_reg;
   logic          valid_reg;
   logic          fault_reg;
   logic [31:0]   fetch_count_reg;
   logic [31:0]   fetch_count_next;

   logic          mem_we;
   logic          sample_en;
   logic          misaligned;
   logic          out_of_range;
   logic          addr_good;
   logic [AW-1:0] rd_idx;

   // Out of range means any address bit above the word-index field is set.
   // This is the same as addr >= 4*DEPTH over the full N bits, without
   // building a wide comparator or truncating the address.
   generate
      if (N > AW + 2) begin : g_upper
         assign out_of_range = |imem_addr_F[N-1:AW+2];
      end else begin : g_no_upper
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign misaligned = |imem_addr_F[1:0];
   assign addr_good  = !misaligned && !out_of_range;
   assign rd_idx     = imem_addr_F[AW+1:2];

   // Next-state and control decode
   always_comb begin
      state_next       = state_reg;
      mem_we           = 1'b0;
      sample_en        = 1'b0;
      fetch_count_next = fetch_count_reg;
      case (state_reg)
         LOAD: begin
            // A write that arrives with load_done still lands, because
            // mem_we and the state change take effect on the same edge.
            mem_we = load_en;
            if (load_done) begin
               state_next = RUN;
            end
         end
         RUN: begin
            sample_en = 1'b1;
            if (addr_good && (fetch_count_reg != CNT_MAX)) begin
               fetch_count_next = fetch_count_reg + 32'd1;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // Control state and response flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= LOAD;
         valid_reg       <= 1'b0;
         fault_reg       <= 1'b0;
         fetch_count_reg <= 32'd0;
      end else begin
         state_reg       <= state_next;
         valid_reg       <= sample_en && addr_good;
         fault_reg       <= sample_en && !addr_good;
         fetch_count_reg <= fetch_count_next;
      end
   end

   // Memory array. It has no reset, so its contents survive a reset.
   // A write that coincides with reset is discarded.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[load_addr] <= load_data;
      end
   end

   // Registered read port. A faulting or idle read is harmless because the
   // flags below decide whether the data is shown.
   always_ff @(posedge clk) begin
      rd_data_reg <= mem[rd_idx];
   end

   // The output select uses only registered flags, so the response keeps a
   // latency of one cycle. When neither flag is set (LOAD, reset, and the
   // first RUN cycle), instr_F is zero.
   assign instr_F     = valid_reg ? rd_data_reg : (fault_reg ? NOP : 32'h0);
   assign instr_valid = valid_reg;
   assign fault       = fault_reg;
   assign fetch_count = fetch_count_reg;

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter N, default 64, instruction address width in bits.
REQ-002 Parameter DEPTH, default 64, number of 32-bit instruction words stored; power of two, 2..1024.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_addr_F  input  N  byte address driven by the fetch stage each cycle.
REQ-006 Port load_en  input  1  program-load write strobe, honoured only in LOAD state.
REQ-007 Port load_addr  input  log2(DEPTH)  word index for the program-load write.
REQ-008 Port load_data  input  32  instruction word for the program-load write.
REQ-009 Port load_done  input  1  one-cycle pulse ending program load.
REQ-010 Port instr_F  output  32  registered instruction word.
REQ-011 Port instr_valid  output  1  instr_F holds a served word.
REQ-012 Port fault  output  1  last sampled address was misaligned or out of range.
REQ-013 Port fetch_count  output  32  number of successfully served words, saturating.

Function
REQ-014 FSM has two states: LOAD and RUN; reset state is LOAD.
REQ-015 In LOAD with load_en=1, mem[load_addr] <= load_data at the clock edge; a later write to the same index overwrites it.
REQ-016 In LOAD with load_done=1, the FSM moves to RUN next cycle; if load_en is also high, the write completes first.
REQ-017 In RUN, load_en and load_done are ignored; memory contents are frozen.
REQ-018 In LOAD, instr_valid=0, fault=0, and instr_F holds 32'h0.
REQ-019 In RUN, imem_addr_F is sampled every cycle; the response appears on instr_F/instr_valid/fault exactly one cycle later (latency 1, one response per cycle, no stalls).
REQ-020 Address is misaligned if imem_addr_F[1:0] != 2'b00.
REQ-021 Address is out of range if imem_addr_F >= 4*DEPTH; comparison uses all N bits, with no truncation.
REQ-022 Good address: instr_F = mem[imem_addr_F[log2(DEPTH)+1:2]], instr_valid=1, fault=0.
REQ-023 Faulting address (misaligned or out of range): instr_F = 32'hD503201F (NOP), instr_valid=0, fault=1.
REQ-024 A misaligned, out-of-range address raises fault only once; fault is a single bit, not a count.
REQ-025 fetch_count increments by 1 on each good response and holds at 32'hFFFFFFFF once reached, with no wrap.
REQ-026 fetch_count does not change on faulting responses or in LOAD.
REQ-027 The first RUN cycle's outputs reflect the LOAD-state values (instr_valid=0); the first response appears on the second RUN cycle.
REQ-028 Memory contents are not cleared by reset; unwritten words read as undefined, and the bench shall not rely on them.

Reset
REQ-029 reset=1 at a clock edge forces: state=LOAD, instr_F=32'h0, instr_valid=0, fault=0, fetch_count=0.
REQ-030 reset has priority over load_en, load_done and reads in the same cycle; a load write coincident with reset is discarded.
REQ-031 reset asserted mid-RUN returns the block to LOAD; the in-flight response is dropped, with no instr_valid the next cycle.

Verification
REQ-032 Load: write 0x8B020020 to index 0 and 0xCB030041 to index 1, pulse load_done, drive addr 0 then 4 -> instr_F=0x8B020020 then 0xCB030041 one cycle after each address, instr_valid=1, fetch_count=2.
REQ-033 Misaligned: in RUN drive addr 0x6 -> next cycle instr_F=0xD503201F, fault=1, instr_valid=0, fetch_count unchanged.
REQ-034 Range (DEPTH=64): addr 0xFC -> valid word at index 63, fault=0; addr 0x100 -> fault=1; addr 0x8000000000000000 -> fault=1.
REQ-035 Load/done collision: load_en=1 on index 5 with data 0x12345678 and load_done=1 in the same cycle, then read addr 0x14 -> instr_F=0x12345678; load_en=1 while in RUN -> memory unchanged.
REQ-036 Saturation: force fetch_count to 32'hFFFFFFFE via hierarchical deposit, serve 3 good reads -> 0xFFFFFFFF and held.
REQ-037 Mid-run reset: assert reset during streaming reads -> next cycle instr_valid=0, fetch_count=0, state=LOAD; reads are ignored until load_done; memory is retained, so after load_done addr 0 returns the previously loaded word.
